// File: rtl/glyph_fetch_unit.sv
// Glyph-row fetch engine: turns {bank, glyph, row} requests into font-memory reads and
// returns row data in order through a credit-protected response FIFO.
module glyph_fetch_unit #(
  parameter int unsigned GLYPH_W     = 8,
  parameter int unsigned ROW_W       = 2,
  parameter int unsigned BANK_W      = 1,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned BASE_ADDR   = 'h400,
  parameter int unsigned BANK_STRIDE = 'h400,
  parameter int unsigned MEM_LAT     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [GLYPH_W-1:0] req_glyph,
  input  logic [ROW_W-1:0]   req_row,
  input  logic [BANK_W-1:0]  req_bank,
  input  logic               req_burst,
  output logic               mem_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic [ROW_W-1:0]   rsp_row,
  output logic               rsp_last,
  output logic               addr_ovf
);
  localparam int unsigned FIFO_DEPTH = MEM_LAT + 2;
  localparam int unsigned SUM_W      = ADDR_W + BANK_W + 2;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = '1;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t              state_reg, state_next;
  logic [GLYPH_W-1:0]  burst_glyph_reg;
  logic [BANK_W-1:0]   burst_bank_reg;
  logic [ROW_W-1:0]    burst_row_reg;
  logic [CNT_W-1:0]    credit_reg, credit_next;
  logic                credit_ok;

  logic                issue;
  logic [GLYPH_W-1:0]  issue_glyph;
  logic [BANK_W-1:0]   issue_bank;
  logic [ROW_W-1:0]    issue_row;
  logic                issue_last;
  logic [SUM_W-1:0]    sum;
  logic                sum_ovf;

  logic                mem_en_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [ROW_W:0]      side_reg;
  logic                addr_ovf_reg;

  logic [MEM_LAT-1:0]  pipe_v_reg, pipe_v_in;
  logic [ROW_W:0]      pipe_side_reg [MEM_LAT];
  logic [ROW_W:0]      pipe_side_in  [MEM_LAT];

  logic [DATA_W-1:0]   fifo_data_reg [FIFO_DEPTH];
  logic [ROW_W:0]      fifo_side_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic                push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign credit_ok = (credit_reg < DEPTH_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (issue && req_burst)  state_next = ST_BURST;
      ST_BURST: if (issue && issue_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    issue       = 1'b0;
    issue_glyph = req_glyph;
    issue_bank  = req_bank;
    issue_row   = req_row;
    issue_last  = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        req_ready = rst_n && credit_ok;
        issue     = req_valid && req_ready;
        if (req_burst) begin
          issue_row  = '0;
          issue_last = 1'b0;
        end
      end
      ST_BURST: begin
        issue       = credit_ok;
        issue_glyph = burst_glyph_reg;
        issue_bank  = burst_bank_reg;
        issue_row   = burst_row_reg;
        issue_last  = (burst_row_reg == ROW_MAX);
      end
      default: ;
    endcase
  end

  // Formed wide enough that any carry past ADDR_W is visible as overflow.
  assign sum = SUM_W'(BASE_ADDR) + SUM_W'(issue_bank) * SUM_W'(BANK_STRIDE)
             + SUM_W'({issue_glyph, issue_row});
  assign sum_ovf = |sum[SUM_W-1:ADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      side_reg        <= '0;
      addr_ovf_reg    <= 1'b0;
      burst_glyph_reg <= '0;
      burst_bank_reg  <= '0;
      burst_row_reg   <= '0;
    end else begin
      mem_en_reg <= issue;
      if (issue) begin
        mem_addr_reg <= sum[ADDR_W-1:0];
        side_reg     <= {issue_row, issue_last};
      end
      if (issue && sum_ovf) addr_ovf_reg <= 1'b1;
      if (state_reg == ST_IDLE && issue && req_burst) begin
        burst_glyph_reg <= req_glyph;
        burst_bank_reg  <= req_bank;
        burst_row_reg   <= ROW_W'(1);
      end else if (state_reg == ST_BURST && issue) begin
        burst_row_reg <= burst_row_reg + 1'b1;
      end
    end
  end

  // Sideband shift pipe: stage MEM_LAT-1 lines up with mem_rdata.
  for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      assign pipe_v_in[gi]    = mem_en_reg;
      assign pipe_side_in[gi] = side_reg;
    end else begin : g_tail
      assign pipe_v_in[gi]    = pipe_v_reg[gi-1];
      assign pipe_side_in[gi] = pipe_side_reg[gi-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v_reg    <= '0;
      pipe_side_reg <= '{default: '0};
    end else begin
      pipe_v_reg    <= pipe_v_in;
      pipe_side_reg <= pipe_side_in;
    end
  end

  assign push = pipe_v_reg[MEM_LAT-1];
  assign pop  = rsp_valid && rsp_ready;

  always_comb begin
    credit_next = credit_reg;
    if (issue && !pop)      credit_next = credit_reg + 1'b1;
    else if (!issue && pop) credit_next = credit_reg - 1'b1;
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + 1'b1;
    else if (!push && pop) count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_reg    <= '0;
      count_reg     <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      fifo_data_reg <= '{default: '0};
      fifo_side_reg <= '{default: '0};
    end else begin
      credit_reg <= credit_next;
      count_reg  <= count_next;
      if (push) begin
        fifo_data_reg[wr_ptr_reg] <= mem_rdata;
        fifo_side_reg[wr_ptr_reg] <= pipe_side_reg[MEM_LAT-1];
        wr_ptr_reg                <= ptr_inc(wr_ptr_reg);
      end
      if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
    end
  end

  assign mem_en    = mem_en_reg;
  assign mem_addr  = mem_addr_reg;
  assign addr_ovf  = addr_ovf_reg;
  assign rsp_valid = (count_reg != '0);
  assign rsp_data  = fifo_data_reg[rd_ptr_reg];
  assign rsp_row   = fifo_side_reg[rd_ptr_reg][ROW_W:1];
  assign rsp_last  = fifo_side_reg[rd_ptr_reg][0];

  // A full FIFO must never coincide with reads still on their way back.
  full_no_inflight: assert property (@(posedge clk) disable iff (!rst_n)
    !((count_reg == DEPTH_C) && (mem_en_reg || (|pipe_v_reg))));

endmodule

// File: tb/tb_glyph_fetch_unit.sv
// Directed bench for glyph_fetch_unit: font memory model plus hand-computed expectations.
module tb_glyph_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_burst;
  logic [7:0]  req_glyph;
  logic [1:0]  req_row;
  logic [0:0]  req_bank;
  logic        mem_en;
  logic [14:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        rsp_valid, rsp_ready, rsp_last, addr_ovf;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_row;

  logic        hi_req_valid, hi_req_ready, hi_mem_en, hi_rsp_valid, hi_rsp_ready;
  logic        hi_rsp_last, hi_addr_ovf;
  logic [14:0] hi_mem_addr;
  logic [15:0] hi_mem_rdata, hi_rsp_data;
  logic [1:0]  hi_rsp_row;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  glyph_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_glyph(req_glyph),
    .req_row(req_row), .req_bank(req_bank), .req_burst(req_burst),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_row(rsp_row), .rsp_last(rsp_last), .addr_ovf(addr_ovf)
  );

  glyph_fetch_unit #(.BASE_ADDR('h7F00)) u_dut_hi (
    .clk(clk), .rst_n(rst_n),
    .req_valid(hi_req_valid), .req_ready(hi_req_ready), .req_glyph(req_glyph),
    .req_row(req_row), .req_bank(req_bank), .req_burst(req_burst),
    .mem_en(hi_mem_en), .mem_addr(hi_mem_addr), .mem_rdata(hi_mem_rdata),
    .rsp_valid(hi_rsp_valid), .rsp_ready(hi_rsp_ready), .rsp_data(hi_rsp_data),
    .rsp_row(hi_rsp_row), .rsp_last(hi_rsp_last), .addr_ovf(hi_addr_ovf)
  );

  function automatic logic [15:0] font_word(input logic [14:0] a);
    return {a[7:0], ~a[14:7]};
  endfunction

  // Font memory with one cycle of read latency.
  always @(posedge clk) if (mem_en) mem_rdata <= font_word(mem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Called just after a falling edge; request is accepted on the next rising edge.
  task automatic run_single(input logic [7:0] g, input logic [1:0] r, input logic b,
                            input logic [14:0] exp_addr);
    req_glyph = g; req_row = r; req_bank = b; req_burst = 1'b0; req_valid = 1'b1;
    rsp_ready = 1'b1;
    check("single_req_ready", req_ready, 1);
    @(negedge clk); req_valid = 1'b0;
    check("single_mem_en", mem_en, 1);
    check("single_mem_addr", mem_addr, exp_addr);
    @(negedge clk);
    check("single_mem_en_once", mem_en, 0);
    check("single_rsp_not_early", rsp_valid, 0);
    @(negedge clk);
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_data", rsp_data, font_word(exp_addr));
    check("single_rsp_row", rsp_row, r);
    check("single_rsp_last", rsp_last, 1);
    @(negedge clk);
    check("single_rsp_drained", rsp_valid, 0);
  endtask

  logic [14:0] burst_addr [4];
  logic [7:0]  s4_glyph [8];
  logic [1:0]  s4_row [8];
  logic [14:0] s4_addr [3];
  int n_iss, n_rsp, n_acc;
  logic stale;

  initial begin
    burst_addr = '{15'h504, 15'h505, 15'h506, 15'h507};
    s4_glyph   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    s4_row     = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    s4_addr    = '{15'h440, 15'h445, 15'h44A};
    mem_rdata = '0; hi_mem_rdata = '0; hi_rsp_ready = 1'b1;
    rst_n = 1'b0; req_valid = 1'b0; hi_req_valid = 1'b0; req_burst = 1'b0;
    req_glyph = '0; req_row = '0; req_bank = '0; rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_addr_ovf", addr_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);

    // Test 1 and 2: single fetches, bank 0 and bank 1.
    run_single(8'h41, 2'd2, 1'b0, 15'h506);
    run_single(8'h41, 2'd2, 1'b1, 15'h906);
    check("bank1_no_ovf", addr_ovf, 0);

    // Test 3: burst of glyph 0x41, row input ignored.
    req_glyph = 8'h41; req_row = 2'd3; req_bank = 1'b0; req_burst = 1'b1; req_valid = 1'b1;
    check("burst_accept_ready", req_ready, 1);
    n_iss = 0; n_rsp = 0;
    for (int cyc = 0; cyc < 30 && n_rsp < 4; cyc++) begin
      @(negedge clk); req_valid = 1'b0; req_burst = 1'b0;
      if (mem_en) begin
        if (n_iss < 4) begin
          check("burst_mem_addr", mem_addr, burst_addr[n_iss]);
          check("burst_req_ready", req_ready, (n_iss == 3) ? 1 : 0);
        end else begin
          check("burst_extra_issue", n_iss, 3);
        end
        n_iss++;
      end else if (n_iss < 4) begin
        check("burst_req_ready_stall", req_ready, 0);
      end
      if (rsp_valid && n_rsp < 4) begin
        check("burst_rsp_row", rsp_row, n_rsp);
        check("burst_rsp_last", rsp_last, (n_rsp == 3) ? 1 : 0);
        check("burst_rsp_data", rsp_data, font_word(burst_addr[n_rsp]));
        n_rsp++;
      end
    end
    check("burst_issues", n_iss, 4);
    check("burst_responses", n_rsp, 4);
    @(negedge clk);

    // Test 4: back-pressure fills the credits, then drain in order.
    rsp_ready = 1'b0; n_acc = 0;
    req_glyph = s4_glyph[0]; req_row = s4_row[0]; req_valid = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (req_ready) begin
        n_acc++;
        $display("     accept %0d glyph 0x%0h", n_acc, req_glyph);
      end
      @(negedge clk);
      req_glyph = s4_glyph[n_acc & 7]; req_row = s4_row[n_acc & 7];
    end
    req_valid = 1'b0;
    check("bp_accepted", n_acc, 3);
    check("bp_req_ready_low", req_ready, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_held", rsp_data, font_word(s4_addr[0]));
    rsp_ready = 1'b1; n_rsp = 0;
    for (int cyc = 0; cyc < 15 && n_rsp < 3; cyc++) begin
      if (rsp_valid) begin
        check("bp_drain_data", rsp_data, font_word(s4_addr[n_rsp]));
        check("bp_drain_row", rsp_row, s4_row[n_rsp]);
        n_rsp++;
      end
      @(negedge clk);
    end
    check("bp_drained", n_rsp, 3);
    check("bp_empty", rsp_valid, 0);
    check("bp_req_ready_back", req_ready, 1);

    // Test 5: address overflow on the high-base instance.
    req_glyph = 8'hFF; req_row = 2'd3; req_bank = 1'b0; req_burst = 1'b0; hi_req_valid = 1'b1;
    check("ovf_req_ready", hi_req_ready, 1);
    @(negedge clk); hi_req_valid = 1'b0;
    check("ovf_mem_en", hi_mem_en, 1);
    check("ovf_mem_addr", hi_mem_addr, 15'h02FF);
    check("ovf_flag", hi_addr_ovf, 1);
    repeat (2) @(negedge clk);
    check("ovf_rsp_valid", hi_rsp_valid, 1);
    check("ovf_rsp_row", hi_rsp_row, 3);
    check("ovf_rsp_last", hi_rsp_last, 1);
    check("ovf_rsp_data", hi_rsp_data, 0);
    repeat (2) @(negedge clk);
    check("ovf_sticky", hi_addr_ovf, 1);
    check("main_no_ovf", addr_ovf, 0);

    // Test 6: reset in the middle of a burst.
    req_glyph = 8'h41; req_row = 2'd0; req_bank = 1'b0; req_burst = 1'b1; req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk); req_valid = 1'b0; req_burst = 1'b0;
    check("midrst_issue0", mem_addr, 15'h504);
    @(negedge clk);
    check("midrst_issue1", mem_addr, 15'h505);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_en", mem_en, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_data", rsp_data, 0);
    check("midrst_rsp_row", rsp_row, 0);
    check("midrst_rsp_last", rsp_last, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_ovf_cleared", hi_addr_ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (rsp_valid || mem_en) stale = 1'b1;
    end
    check("postrst_no_stale", stale, 0);
    run_single(8'h41, 2'd2, 1'b0, 15'h506);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end
endmodule
